canv_vram_arb: RTL and testbench

//  Shares the single VRAM port between the canvas display fetch and two system requesters.
//  The display fetch comes from the display AGU's addr output and has absolute priority,
//  so it keeps a fixed, stall-free latency. System port 0 (CPU) and port 1 (blitter)

---
 rtl/canv_vram_arb.sv | 140 ++++++++++++++
 tb/tb_canv_vram_arb.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/canv_vram_arb.sv
// VRAM port arbiter: the display fetch always wins, and the two system ports
// round-robin over the idle cycles. Read data returns through a tag pipeline matched to VRAM latency.
module canv_vram_arb #(
  parameter int ADDRW    = 14,
  parameter int WORD     = 32,
  parameter int VRAM_LAT = 1
) (
  input  logic               clk_pix,
  input  logic               rst_pix_n,
  input  logic               disp_req,
  input  logic [ADDRW-1:0]   disp_addr,
  output logic [WORD-1:0]    disp_data,
  output logic               disp_data_valid,
  input  logic [1:0]         s_valid,
  output logic [1:0]         s_ready,
  input  logic [1:0]         s_we,
  input  logic [2*ADDRW-1:0] s_addr,
  input  logic [2*WORD-1:0]  s_wdata,
  output logic [WORD-1:0]    s_rdata,
  output logic [1:0]         s_rvalid,
  output logic               vram_en,
  output logic               vram_we,
  output logic [ADDRW-1:0]   vram_addr,
  output logic [WORD-1:0]    vram_wdata,
  input  logic [WORD-1:0]    vram_rdata
);

  typedef enum logic [1:0] {
    SRC_DISP = 2'd0,
    SRC_P0   = 2'd1,
    SRC_P1   = 2'd2
  } src_e;

  typedef struct packed {
    logic valid;
    src_e src;
  } tag_t;

  logic             rr_q, rr_d;
  logic             grant_sys;
  logic             win_port;
  logic             vram_en_q, vram_en_d;
  logic             vram_we_q, vram_we_d;
  logic [ADDRW-1:0] vram_addr_q, vram_addr_d;
  logic [WORD-1:0]  vram_wdata_q, vram_wdata_d;
  src_e             cmd_src_q, cmd_src_d;
  tag_t             tag_q [VRAM_LAT];
  tag_t             tail;
  logic             disp_hit, p0_hit, p1_hit;
  logic [WORD-1:0]  disp_data_q;
  logic             disp_data_valid_q;
  logic [WORD-1:0]  s_rdata_q;
  logic [1:0]       s_rvalid_q;

  // Grant: display first, then a lone requester, then the rr choice.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    grant_sys = 1'b0;
    win_port  = 1'b0;
    if (!disp_req) begin
      case (s_valid)
        2'b01:   begin grant_sys = 1'b1; win_port = 1'b0; end
        2'b10:   begin grant_sys = 1'b1; win_port = 1'b1; end
        2'b11:   begin grant_sys = 1'b1; win_port = rr_q; end
        default: ;
      endcase
    end
    s_ready = 2'b00;
    // Ready is combinational, so it is gated here to keep it low while reset is held.
    if (grant_sys && rst_pix_n) s_ready[win_port] = 1'b1;
  end

  always_comb begin
    rr_d         = rr_q;
    vram_en_d    = disp_req | grant_sys;
    vram_we_d    = 1'b0;
    vram_addr_d  = vram_addr_q;
    vram_wdata_d = vram_wdata_q;
    cmd_src_d    = SRC_DISP;
    if (disp_req) begin
      vram_addr_d = disp_addr;
    end else if (grant_sys) begin
      rr_d        = ~win_port;
      vram_we_d   = s_we[win_port];
      vram_addr_d = win_port ? s_addr[ADDRW +: ADDRW] : s_addr[0 +: ADDRW];
      cmd_src_d   = win_port ? SRC_P1 : SRC_P0;
      if (s_we[win_port])
        vram_wdata_d = win_port ? s_wdata[WORD +: WORD] : s_wdata[0 +: WORD];
    end
  end

  always_comb begin
    tail     = tag_q[VRAM_LAT-1];
    disp_hit = tail.valid && (tail.src == SRC_DISP);
    p0_hit   = tail.valid && (tail.src == SRC_P0);
    p1_hit   = tail.valid && (tail.src == SRC_P1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      rr_q              <= 1'b0;
      vram_en_q         <= 1'b0;
      vram_we_q         <= 1'b0;
      vram_addr_q       <= '0;
      vram_wdata_q      <= '0;
      cmd_src_q         <= SRC_DISP;
      disp_data_q       <= '0;
      disp_data_valid_q <= 1'b0;
      s_rdata_q         <= '0;
      s_rvalid_q        <= 2'b00;
      // NOTE: the tag array is reset, unlike a data RAM, so pre-reset reads never return.
      for (int i = 0; i < VRAM_LAT; i++) tag_q[i] <= '0;
    end else begin
      rr_q         <= rr_d;
      vram_en_q    <= vram_en_d;
      vram_we_q    <= vram_we_d;
      vram_addr_q  <= vram_addr_d;
      vram_wdata_q <= vram_wdata_d;
      cmd_src_q    <= cmd_src_d;
      // Stage 0 mirrors the command now on the VRAM pins; the last stage lines up with vram_rdata.
      tag_q[0] <= '{valid: vram_en_q & ~vram_we_q, src: cmd_src_q};
      for (int i = 1; i < VRAM_LAT; i++) tag_q[i] <= tag_q[i-1];
      disp_data_valid_q <= disp_hit;
      s_rvalid_q        <= {p1_hit, p0_hit};
      if (disp_hit)          disp_data_q <= vram_rdata;
      if (p0_hit || p1_hit)  s_rdata_q   <= vram_rdata;
    end
  end

  assign vram_en         = vram_en_q;
  assign vram_we         = vram_we_q;
  assign vram_addr       = vram_addr_q;
  assign vram_wdata      = vram_wdata_q;
  assign disp_data       = disp_data_q;
  assign disp_data_valid = disp_data_valid_q;
  assign s_rdata         = s_rdata_q;
  assign s_rvalid        = s_rvalid_q;

endmodule

// File: tb/tb_canv_vram_arb.sv
// Bench for canv_vram_arb: directed vectors with a response scoreboard
// checked by an independent monitor against cycle-exact arrival times.
module tb_canv_vram_arb;
  localparam int ADDRW = 14;
  localparam int WORD  = 32;

  logic               clk_pix = 1'b0;
  logic               rst_pix_n = 1'b0;
  logic               disp_req = 1'b0;
  logic [ADDRW-1:0]   disp_addr = '0;
  logic [WORD-1:0]    disp_data;
  logic               disp_data_valid;
  logic [1:0]         s_valid = '0;
  logic [1:0]         s_ready;
  logic [1:0]         s_we = '0;
  logic [2*ADDRW-1:0] s_addr = '0;
  logic [2*WORD-1:0]  s_wdata = '0;
  logic [WORD-1:0]    s_rdata;
  logic [1:0]         s_rvalid;
  logic               vram_en;
  logic               vram_we;
  logic [ADDRW-1:0]   vram_addr;
  logic [WORD-1:0]    vram_wdata;
  logic [WORD-1:0]    vram_rdata = '0;

  canv_vram_arb #(.ADDRW(ADDRW), .WORD(WORD), .VRAM_LAT(1)) dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_data(disp_data), .disp_data_valid(disp_data_valid),
    .s_valid(s_valid), .s_ready(s_ready), .s_we(s_we),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .vram_en(vram_en), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
  );

  always #5 clk_pix = ~clk_pix;

  int cyc = 0;
  always @(posedge clk_pix) cyc++;

  logic [WORD-1:0] vram_mem [1<<ADDRW];
  logic [WORD-1:0] ref_mem  [1<<ADDRW];

  // One-cycle-latency VRAM macro.
  always @(posedge clk_pix) begin
    if (vram_en) begin
      if (vram_we) vram_mem[vram_addr] <= vram_wdata;
      else         vram_rdata <= vram_mem[vram_addr];
    end
  end

  function automatic logic [WORD-1:0] model_word(input logic [ADDRW-1:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  logic [116:0] outs_all;
  assign outs_all = {disp_data, disp_data_valid, s_ready, s_rdata, s_rvalid,
                     vram_en, vram_we, vram_addr, vram_wdata};

  typedef struct {
    int              src;
    logic [WORD-1:0] data;
    int              cyc;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Inputs are already driven (posedge+1). Check ready, record expectations, move to the next cycle.
  task automatic tick(input logic [1:0] exp_ready, input bit push_en = 1'b1);
    #1;
    check("s_ready", 128'(s_ready), 128'(exp_ready));
    if (push_en) begin
      if (disp_req) begin
        sb.push_back('{src: 0, data: ref_mem[disp_addr], cyc: cyc + 3});
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (exp_ready[i]) begin
            logic [ADDRW-1:0] a;
            a = s_addr[i*ADDRW +: ADDRW];
            if (s_we[i]) ref_mem[a] = s_wdata[i*WORD +: WORD];
            else sb.push_back('{src: i + 1, data: ref_mem[a], cyc: cyc + 3});
          end
        end
      end
    end
    @(posedge clk_pix);
    #1;
  endtask

  task automatic idle(input int n);
    disp_req = 1'b0;
    s_valid  = 2'b00;
    s_we     = 2'b00;
    repeat (n) tick(2'b00);
  endtask

  // Monitor: every response pulse must match the oldest expectation, on the expected cycle.
  always @(negedge clk_pix) begin
    if (rst_pix_n && (disp_data_valid || s_rvalid != 2'b00)) begin
      int              a_src;
      logic [WORD-1:0] a_data;
      exp_t            e;
      if (disp_data_valid && s_rvalid == 2'b00) begin
        a_src = 0; a_data = disp_data;
      end else if (!disp_data_valid && s_rvalid == 2'b01) begin
        a_src = 1; a_data = s_rdata;
      end else if (!disp_data_valid && s_rvalid == 2'b10) begin
        a_src = 2; a_data = s_rdata;
      end else begin
        a_src = 3; a_data = '0;
      end
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp @cycle %0d: got src %0d data %0h, expected no response",
                 cyc, a_src, a_data);
      end else begin
        e = sb.pop_front();
        check("rsp_src",   128'(a_src),  128'(e.src));
        check("rsp_data",  128'(a_data), 128'(e.data));
        check("rsp_cycle", 128'(cyc),    128'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < (1 << ADDRW); a++) begin
      vram_mem[a] = model_word(ADDRW'(a));
      ref_mem[a]  = model_word(ADDRW'(a));
    end

    // 1: reset with random inputs, then release with idle inputs.
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_pix);
      #1;
      disp_req  = 1'($urandom());
      disp_addr = ADDRW'($urandom());
      s_valid   = 2'($urandom());
      s_we      = 2'($urandom());
      s_addr    = 28'($urandom());
      s_wdata   = {$urandom(), $urandom()};
      #1;
      check("reset_outputs", 128'(outs_all), 128'(0));
    end
    @(posedge clk_pix);
    #1;
    disp_req = 1'b0; s_valid = 2'b00; s_we = 2'b00;
    s_addr = '0; s_wdata = '0; disp_addr = '0;
    rst_pix_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("post_reset_outputs", 128'(outs_all), 128'(0));
      @(posedge clk_pix);
      #1;
    end

    // 2: ten display fetches with port 0 waiting; port 0 must never be ready.
    s_valid = 2'b01;
    s_addr[0 +: ADDRW] = 14'h0055;
    for (int i = 0; i < 10; i++) begin
      disp_req  = 1'b1;
      disp_addr = ADDRW'(i);
      tick(2'b00);
      check("disp_vram_addr", 128'(vram_addr), 128'(i));
      check("disp_vram_we",   128'(vram_we),   128'(0));
    end
    idle(4);

    // 3: both ports valid, alternating grants starting at port 0.
    s_valid = 2'b11;
    s_we    = 2'b00;
    s_addr  = {14'h0200, 14'h0100};
    for (int k = 0; k < 6; k++) begin
      tick((k % 2) != 0 ? 2'b10 : 2'b01);
      check("rr_vram_addr", 128'(vram_addr), (k % 2) != 0 ? 128'(14'h0200) : 128'(14'h0100));
    end
    idle(4);

    // 4: port 0 write then read of the same word.
    s_valid = 2'b01;
    s_we    = 2'b01;
    s_addr[0 +: ADDRW] = 14'h0010;
    s_wdata[0 +: WORD] = 32'hDEAD_BEEF;
    tick(2'b01);
    check("wr_vram_we",    128'(vram_we),    128'(1));
    check("wr_vram_wdata", 128'(vram_wdata), 128'(32'hDEAD_BEEF));
    check("wr_vram_addr",  128'(vram_addr),  128'(14'h0010));
    s_we = 2'b00;
    tick(2'b01);
    check("rd_vram_we",    128'(vram_we),    128'(0));
    idle(4);

    // 5: port 1 read then display read; responses return in grant order.
    s_valid = 2'b10;
    s_addr[ADDRW +: ADDRW] = 14'h0020;
    tick(2'b10);
    s_valid   = 2'b00;
    disp_req  = 1'b1;
    disp_addr = 14'h0030;
    tick(2'b00);
    idle(5);

    // 6: reset right after an accepted read; that read must never return.
    s_valid = 2'b01;
    s_addr[0 +: ADDRW] = 14'h0040;
    tick(2'b01, 1'b0);
    s_valid   = 2'b00;
    rst_pix_n = 1'b0;
    #1;
    check("midrst_outputs", 128'(outs_all), 128'(0));
    @(posedge clk_pix);
    #1;
    check("midrst_outputs_held", 128'(outs_all), 128'(0));
    @(posedge clk_pix);
    #1;
    rst_pix_n = 1'b1;
    idle(4);
    s_valid = 2'b11;
    s_addr  = {14'h0070, 14'h0060};
    tick(2'b01);
    idle(5);

    check("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
